// File: rtl/fifo_pcie_param.sv
// fifo_pcie_param: synchronous single-clock FIFO with programmable
// almost-full / almost-empty thresholds and a registered read port.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   init              loads umbral_AF_in / umbral_AE_in into the threshold regs
//   push, data_in     write request and data
//   pop               read request
//   data_out          registered read data, valid one cycle after an accepted pop
//   data_valid        one-cycle pulse marking a data_out update
//   count             occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   registered status flags
//   overflow, underflow  sticky error flags, only with FIFO_ERR_FLAGS_EN
//
// Build option: define FIFO_ERR_FLAGS_EN to add the overflow/underflow ports.
module fifo_pcie_param #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_AF_in,
  input  logic [ADDR_W:0]   umbral_AE_in,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
`else
  output logic              almost_empty
`endif
);

  localparam int            DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_RST  = DEPTH_C - 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   af_thr, ae_thr;
  logic [ADDR_W:0]   count_nxt;
  logic              push_ok, pop_ok;

  // A full FIFO still takes a push when a pop frees the slot in the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      af_thr       <= AF_RST;
      ae_thr       <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      // Nonblocking read of mem gives read-before-write when pointers coincide.
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      data_valid <= pop_ok;
      count      <= count_nxt;
      // Flags track the post-edge count; a threshold loaded this edge
      // only takes effect from the following edge.
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= af_thr);
      almost_empty <= (count_nxt <= ae_thr);
      if (init) begin
        af_thr <= umbral_AF_in;
        ae_thr <= umbral_AE_in;
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && !pop_ok)   underflow <= 1'b1;
    end
  end
`endif

endmodule
